// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: state encodings,
// default width and the iteration-counter width helper.
package seq_div_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int STATE_W        = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_CALC = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    // One extra bit so the counter can represent DATA_W itself.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] partial_rem,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] new_rem,
    output logic              quot_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    assign shifted = {partial_rem, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};

    // partial_rem < divisor always holds, so shifted < 2*divisor and the
    // borrow out of the (DATA_W+1)-bit subtract is exactly "does not fit".
    assign quot_bit = ~diff[DATA_W];
    assign new_rem  = quot_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider with valid/ready handshakes on both sides:
// one restoring step per cycle, divide-by-zero short-cut to DONE.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_quot,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_dbz
);

    localparam int               CNT_W     = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    logic [STATE_W-1:0] state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]  work_reg;
    logic [DATA_W-1:0]  divisor_reg;
    logic [DATA_W-1:0]  rem_reg;
    logic [DATA_W-1:0]  out_quot_reg;
    logic [DATA_W-1:0]  out_rem_reg;
    logic               out_dbz_reg;

    logic [DATA_W-1:0]  rem_next;
    logic [DATA_W-1:0]  work_next;
    logic               quot_bit;

    div_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .partial_rem (rem_reg),
        .dividend_bit(work_reg[DATA_W-1]),
        .divisor     (divisor_reg),
        .new_rem     (rem_next),
        .quot_bit    (quot_bit)
    );

    // The dividend drains out of the top of work_reg while quotient bits
    // fill in from the bottom; after DATA_W steps it holds the quotient.
    assign work_next = {work_reg[DATA_W-2:0], quot_bit};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            work_reg     <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            out_quot_reg <= '0;
            out_rem_reg  <= '0;
            out_dbz_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid) begin
                        work_reg    <= i_a;
                        divisor_reg <= i_b;
                        cnt_reg     <= '0;
                        rem_reg     <= '0;
                        if (i_b == '0) begin
                            state_reg    <= ST_DONE;
                            out_quot_reg <= '1;
                            out_rem_reg  <= i_a;
                            out_dbz_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    work_reg <= work_next;
                    rem_reg  <= rem_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP) begin
                        state_reg    <= ST_DONE;
                        out_quot_reg <= work_next;
                        out_rem_reg  <= rem_next;
                        out_dbz_reg  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready = (state_reg == ST_IDLE);
    assign o_valid = (state_reg == ST_DONE);
    assign o_quot  = out_quot_reg;
    assign o_rem   = out_rem_reg;
    assign o_dbz   = out_dbz_reg;

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter DATA_W, default 8, operand/quotient/remainder width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 i_valid  input  1  request valid; operands presented on i_a/i_b.
REQ-005 o_ready  output  1  block can accept a request.
REQ-006 i_a  input  DATA_W  dividend, unsigned.
REQ-007 i_b  input  DATA_W  divisor, unsigned.
REQ-008 o_valid  output  1  result valid on o_quot/o_rem/o_dbz.
REQ-009 i_ready  input  1  consumer accepts the result.
REQ-010 o_quot  output  DATA_W  quotient, unsigned.
REQ-011 o_rem  output  DATA_W  remainder, unsigned.
REQ-012 o_dbz  output  1  divide-by-zero flag for the current result.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-015 Accept = i_valid && o_ready on a rising edge; operands SHALL be captured on that edge and not re-sampled afterwards.
REQ-016 On accept with i_b != 0: IDLE->CALC, iteration counter cleared to 0, partial remainder cleared to 0.
REQ-017 In CALC the block SHALL perform one restoring step per cycle, MSB first: shift in the next dividend bit, subtract the divisor if the partial remainder is >= the divisor, and set that quotient bit.
REQ-018 After exactly DATA_W steps CALC->DONE; o_valid SHALL be first visible DATA_W cycles after the accept edge (8 for the default).
REQ-019 On accept with i_b == 0: IDLE->DONE directly (o_valid 1 cycle after accept); o_quot = all ones, o_rem = i_a, o_dbz = 1.
REQ-020 For i_b != 0: o_quot = floor(i_a/i_b), o_rem = i_a mod i_b, o_dbz = 0; internal subtract width SHALL be DATA_W+1 bits so no overflow is possible at i_a = all ones.
REQ-021 In DONE, o_valid/o_quot/o_rem/o_dbz SHALL be held stable until o_valid && i_ready; on that edge DONE->IDLE.
REQ-022 i_valid during CALC or DONE SHALL be ignored, with no effect on the computation in progress.
REQ-023 i_ready while not in DONE SHALL have no effect.
REQ-024 In IDLE and CALC, o_quot/o_rem/o_dbz SHALL hold their last completed values.

Reset
REQ-025 reset_n == 0 at a rising edge SHALL force IDLE, clear the counter, and set o_valid = 0, o_ready = 1 (first cycle after release), o_quot = 0, o_rem = 0, o_dbz = 0.
REQ-026 Reset in CALC or DONE SHALL abandon the operation; no o_valid SHALL follow for it.
REQ-027 Reset SHALL take priority over a simultaneous accept or i_ready.

Structure
REQ-028 State encodings (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2) and DATA_W default SHALL live in shared package seq_div_pkg, for reuse by the bench.
REQ-029 The single restoring step SHALL be one combinational sub-module, div_step: inputs partial remainder, next dividend bit, divisor; outputs new remainder and quotient bit.
REQ-030 The counter SHALL be $clog2(DATA_W)+1 bits wide.

Verification
REQ-031 i_a = 30, i_b = 10, i_ready = 1 -> o_valid 8 cycles after accept; o_quot = 3, o_rem = 0, o_dbz = 0.
REQ-032 i_a = 255, i_b = 1 -> o_quot = 255, o_rem = 0; then i_a = 7, i_b = 9 -> o_quot = 0, o_rem = 7.
REQ-033 i_a = 100, i_b = 0 -> o_valid 1 cycle after accept; o_quot = 255, o_rem = 100, o_dbz = 1.
REQ-034 i_a = 200, i_b = 7, i_ready held 0 for 5 cycles -> o_valid and o_quot = 28, o_rem = 4 stable throughout; IDLE and o_ready = 1 one cycle after i_ready = 1.
REQ-035 Accept 50/3, assert reset_n = 0 at step 4, release, then submit 9/2 -> no o_valid for 50/3; o_quot = 4, o_rem = 1 for 9/2.
REQ-036 1000 random i_a/i_b pairs, including i_b = 0, with random i_valid/i_ready -> every result matches a reference model of a/b, a%b and the REQ-019 rule.
